// File: rtl/dco_freq_lock.sv
// dco_freq_lock: gated edge-count frequency-lock loop driving an 8-bit DCO code.
// Define DCO_FREQ_LOCK_BINSEARCH_EN for an 8-window successive-approximation start-up.
module dco_freq_lock #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GATE_CYCLES  = 1024,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter logic [7:0]  INIT_CODE    = 8'h80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             dco_in,
    input  logic [CNT_W-1:0] target_count,
    output logic [7:0]       dco_code,
    output logic             locked,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid
);
    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned LCK_W  = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned CW1    = CNT_W + 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [LCK_W-1:0]  LOCK_MAX  = LCK_W'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    TOL_X     = CW1'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        UPDATE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic [7:0]        code_q, code_d;
    logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    logic              edge_det;
    logic [CNT_W-1:0]  edge_nxt;
    logic [CNT_W:0]    tgt_x, hi_sum;
    logic [CNT_W-1:0]  lo_bnd, hi_bnd;
    logic              below, above;

`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
    logic              srch_q, srch_d;
    logic [2:0]        srch_k_q, srch_k_d;
    logic [7:0]        srch_bit;

    assign srch_bit = 8'h80 >> srch_k_q;
`endif

    // Two synchroniser flops plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], dco_in};
        end
    end

    assign edge_det = sync_q[1] & ~sync_q[2];
    assign edge_nxt = (edge_q == CNT_MAX) ? edge_q : edge_q + CNT_W'(1);

    assign tgt_x  = {1'b0, target_q};
    assign hi_sum = tgt_x + TOL_X;
    assign lo_bnd = (tgt_x >= TOL_X) ? target_q - TOL_X[CNT_W-1:0] : '0;
    assign hi_bnd = hi_sum[CNT_W] ? CNT_MAX : hi_sum[CNT_W-1:0];
    assign below  = meas_q < lo_bnd;
    assign above  = meas_q > hi_bnd;

    assign dco_code   = code_q;
    assign locked     = locked_q;
    assign meas_count = meas_q;
    assign meas_valid = (state_q == UPDATE);

    // Window sequencing, code stepping and lock bookkeeping.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        target_d   = target_q;
        meas_d     = meas_q;
        code_d     = code_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
        srch_d     = srch_q;
        srch_k_d   = srch_k_q;
`endif
        unique case (state_q)
            IDLE: begin
                gate_d     = '0;
                edge_d     = '0;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
                if (enable) begin
                    state_d  = MEASURE;
                    target_d = target_count;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
                    code_d   = 8'h80;
                    srch_d   = 1'b1;
                    srch_k_d = 3'd0;
`else
                    code_d   = INIT_CODE;
`endif
                end
            end
            MEASURE: begin
                if (edge_det) begin
                    edge_d = edge_nxt;
                end
                gate_d = gate_q + GATE_W'(1);
                if (gate_q == GATE_LAST) begin
                    state_d = UPDATE;
                    gate_d  = '0;
                    meas_d  = edge_d;
                end
            end
            UPDATE: begin
                state_d  = MEASURE;
                gate_d   = '0;
                edge_d   = '0;
                target_d = target_count;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
                if (srch_q) begin
                    code_d = above ? (code_q & ~srch_bit) : code_q;
                    if (srch_k_q == 3'd7) begin
                        srch_d = 1'b0;
                    end else begin
                        code_d   = code_d | (srch_bit >> 1);
                        srch_k_d = srch_k_q + 3'd1;
                    end
                end else
`endif
                begin
                    if (below || above) begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        if (below && code_q != 8'hFF) begin
                            code_d = code_q + 8'd1;
                        end
                        if (above && code_q != 8'h00) begin
                            code_d = code_q - 8'd1;
                        end
                    end else begin
                        if (lock_cnt_q != LOCK_MAX) begin
                            lock_cnt_d = lock_cnt_q + LCK_W'(1);
                        end
                        locked_d = (lock_cnt_d == LOCK_MAX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Dropping enable abandons the window but keeps the code and last count.
        if (!enable) begin
            state_d    = IDLE;
            gate_d     = '0;
            edge_d     = '0;
            target_d   = target_q;
            code_d     = code_q;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end
    end

    // Loop state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gate_q     <= '0;
            edge_q     <= '0;
            target_q   <= '0;
            meas_q     <= '0;
            code_q     <= INIT_CODE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
            srch_q     <= 1'b0;
            srch_k_q   <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            target_q   <= target_d;
            meas_q     <= meas_d;
            code_q     <= code_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
            srch_q     <= srch_d;
            srch_k_q   <= srch_k_d;
`endif
        end
    end

endmodule

// File: tb/tb_dco_freq_lock.sv
// tb_dco_freq_lock: closed-loop bench with a synchronous DCO plant model.
// Plant: (code >> 2) + offset edges per window, gate shortened to 128 cycles.
module tb_dco_freq_lock;
    localparam int GATE = 128;
    localparam int TOL  = 2;
    localparam int LW   = 4;
    localparam int MAXC = 65535;
    localparam int INIT = 128;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        dco_in;
    logic [15:0] target_count;
    logic [7:0]  dco_code;
    logic        locked;
    logic [15:0] meas_count;
    logic        meas_valid;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    int m_code, m_lc, m_tgt, m_off, m_k;
    bit m_lock, m_srch;

    dco_freq_lock #(
        .CNT_W(16),
        .GATE_CYCLES(GATE),
        .TOL(TOL),
        .LOCK_WINDOWS(LW),
        .INIT_CODE(8'h80)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .dco_in(dco_in),
        .target_count(target_count),
        .dco_code(dco_code),
        .locked(locked),
        .meas_count(meas_count),
        .meas_valid(meas_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input int cnt);
        int lo, hi, msk;
        lo = (m_tgt >= TOL) ? m_tgt - TOL : 0;
        hi = (m_tgt + TOL > MAXC) ? MAXC : m_tgt + TOL;
        if (m_srch) begin
            msk = 128 >> m_k;
            if (cnt > hi) m_code = m_code & ~msk;
            if (m_k == 7) begin
                m_srch = 0;
            end else begin
                m_code = m_code | (msk >> 1);
                m_k++;
            end
        end else if (cnt < lo || cnt > hi) begin
            m_lc = 0;
            m_lock = 0;
            if (cnt < lo && m_code < 255) m_code++;
            if (cnt > hi && m_code > 0) m_code--;
        end else begin
            if (m_lc < LW) m_lc++;
            m_lock = (m_lc == LW);
        end
    endtask

    task automatic start_loop();
        enable = 1'b1;
        m_lc = 0;
        m_lock = 0;
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
        m_code = 128;
        m_srch = 1;
        m_k = 0;
`else
        m_code = INIT;
        m_srch = 0;
`endif
    endtask

    // Called at the falling edge just before a window's first gate cycle.
    task automatic run_window(input int tgt_mid);
        int n, cnt;
        m_tgt = int'(target_count);
        n = (m_code >> 2) + m_off;
        exp_q.push_back(n);
        for (int k = 0; k < GATE; k++) begin
            dco_in = ((k % 2) == 0) && ((k / 2) < n);
            @(negedge clk);
            if (k == 0) begin
                chk("code", 32'(dco_code), 32'(m_code));
                chk("locked", 32'(locked), 32'(m_lock));
            end
            if (k == GATE / 2) begin
                chk("valid_mid", 32'(meas_valid), 32'd0);
                if (tgt_mid >= 0) target_count = 16'(tgt_mid);
            end
        end
        dco_in = 1'b0;
        @(negedge clk);
        chk("valid_upd", 32'(meas_valid), 32'd1);
        cnt = exp_q.pop_front();
        chk("meas", 32'(meas_count), 32'(cnt));
        model_update(cnt);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        enable = 1'b0;
        dco_in = 1'b0;
        target_count = '0;
        m_off = 0;
        m_srch = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle with enable low
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            dco_in = i[0];
            @(negedge clk);
            if (meas_valid === 1'b1) pulses++;
        end
        dco_in = 1'b0;
        chk("rst_code", 32'(dco_code), 32'h80);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_meas", 32'(meas_count), 32'd0);
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Acquire and lock on target 36
        target_count = 16'd36;
        start_loop();
        repeat (9) run_window(-1);
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
        chk("search_final", 32'(dco_code), 32'h9B);
`else
        chk("step_code", 32'(dco_code), 32'h88);
`endif
        repeat (5) run_window(-1);
        chk("lock1", 32'(locked), 32'd1);
`ifdef DCO_FREQ_LOCK_BINSEARCH_EN
        chk("lock1_meas", 32'(meas_count), 32'd38);
`else
        chk("lock1_meas", 32'(meas_count), 32'd34);
`endif

        // Retarget mid-window; takes effect next window
        run_window(30);
        repeat (30) run_window(-1);
        chk("relock_code", 32'(dco_code), 32'h83);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_meas", 32'(meas_count), 32'd32);

        // Unreachable high target saturates at 0xFF
        target_count = 16'd2000;
        repeat (130) run_window(-1);
        chk("sat_hi_code", 32'(dco_code), 32'hFF);
        chk("sat_hi_meas", 32'(meas_count), 32'd63);
        chk("sat_hi_lock", 32'(locked), 32'd0);

        enable = 1'b0;
        @(negedge clk);
        chk("dis_code", 32'(dco_code), 32'hFF);
        chk("dis_valid", 32'(meas_valid), 32'd0);

        // Target 0 with plant offset saturates at 0x00
        target_count = 16'd0;
        m_off = 8;
        start_loop();
        repeat (134) run_window(-1);
        chk("sat_lo_code", 32'(dco_code), 32'h00);
        chk("sat_lo_meas", 32'(meas_count), 32'd8);
        chk("sat_lo_lock", 32'(locked), 32'd0);

        // Drop enable mid-window
        m_off = 0;
        target_count = 16'd36;
        for (int k = 0; k < 40; k++) begin
            dco_in = ((k % 2) == 0);
            @(negedge clk);
        end
        dco_in = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("drop_locked", 32'(locked), 32'd0);
        chk("drop_valid", 32'(meas_valid), 32'd0);
        chk("drop_code", 32'(dco_code), 32'h00);
        chk("drop_meas", 32'(meas_count), 32'd8);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (meas_valid === 1'b1) pulses++;
        end
        chk("drop_pulses", 32'(pulses), 32'd0);

        // Re-enable: full window only, then lock again
        start_loop();
        repeat (13) run_window(-1);
        chk("pre_rst_lock", 32'(locked), 32'd1);

        // Asynchronous reset mid-window, between clock edges
        for (int k = 0; k < 30; k++) begin
            dco_in = ((k % 2) == 0);
            @(negedge clk);
        end
        dco_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_code", 32'(dco_code), 32'h80);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_meas", 32'(meas_count), 32'd0);
        chk("arst_valid", 32'(meas_valid), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (meas_valid === 1'b1) pulses++;
        end
        chk("post_rst_pulses", 32'(pulses), 32'd0);
        chk("post_rst_code", 32'(dco_code), 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
